// File: rtl/pong_game_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pong_game_ctrl_pkg
// Description : Shared definitions for the Pong game sequencer: game state
//               encodings, BCD digit limit and a small BCD helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pong_game_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_NEWGAME = 2'd0;
    localparam state_t ST_PLAY    = 2'd1;
    localparam state_t ST_NEWBALL = 2'd2;
    localparam state_t ST_OVER    = 2'd3;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // True when a two-digit BCD value sits at 99.
    function automatic logic bcd_at_max(input logic [3:0] d1, input logic [3:0] d0);
        return (d1 == BCD_MAX) && (d0 == BCD_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pong_game_ctrl_bcd2_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd2_counter
// Description : Two-digit BCD up-counter with synchronous clear, saturating
//               at 99. Clear has priority over increment.
// Ports       : clk  - system clock
//               rst  - asynchronous active-high reset (counter -> 00)
//               clr  - synchronous clear to 00
//               inc  - increment by one (ignored at 99)
//               d1   - BCD tens digit
//               d0   - BCD ones digit
// Revision    : 1.0 - initial release
// ============================================================================
module bcd2_counter
    import pong_game_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] d1,
    output logic [3:0] d0
);

    logic [3:0] d1_q, d1_d;
    logic [3:0] d0_q, d0_d;

    always_comb begin
        d1_d = d1_q;
        d0_d = d0_q;
        if (clr) begin
            d1_d = 4'd0;
            d0_d = 4'd0;
        end else if (inc && !bcd_at_max(d1_q, d0_q)) begin
            if (d0_q == BCD_MAX) begin
                d0_d = 4'd0;
                d1_d = d1_q + 4'd1;
            end else begin
                d0_d = d0_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d1_q <= 4'd0;
            d0_q <= 4'd0;
        end else begin
            d1_q <= d1_d;
            d0_q <= d0_d;
        end
    end

    assign d1 = d1_q;
    assign d0 = d0_q;

endmodule
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pong_game_ctrl
// Description : Game-level sequencer for the Pong graphics datapath. Freezes
//               or releases the animation, issues the one-cycle serve pulse,
//               keeps a saturating two-digit BCD score and tracks lives.
// Ports       : clk        - system clock
//               rst        - asynchronous active-high reset
//               btn[1:0]   - paddle buttons; any bit high = start/serve
//               refr_tick  - one pulse per video frame
//               hit        - ball bounced off paddle (pulse)
//               miss       - ball passed right edge (pulse)
//               gra_still  - 1 freezes ball and paddle motion
//               serve      - one-cycle pulse reloading the ball
//               score_d1   - BCD tens digit of score
//               score_d0   - BCD ones digit of score
//               lives      - remaining lives
//               game_over  - high while the game-over screen is shown
// Revision    : 1.0 - initial release
// ============================================================================
module pong_game_ctrl
    import pong_game_ctrl_pkg::*;
#(
    parameter int LIVES_INIT   = 3,
    parameter int SERVE_FRAMES = 120,
    parameter int OVER_FRAMES  = 180,
    parameter int TW           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] btn,
    input  logic       refr_tick,
    input  logic       hit,
    input  logic       miss,
    output logic       gra_still,
    output logic       serve,
    output logic [3:0] score_d1,
    output logic [3:0] score_d0,
    output logic [1:0] lives,
    output logic       game_over
);

    localparam logic [TW-1:0] C_SERVE_LOAD = TW'(SERVE_FRAMES);
    localparam logic [TW-1:0] C_OVER_LOAD  = TW'(OVER_FRAMES);
    localparam logic [1:0]    C_LIVES_INIT = 2'(LIVES_INIT);

    state_t        state_q,     state_d;
    logic [TW-1:0] timer_q,     timer_d;
    logic [1:0]    lives_q,     lives_d;
    logic          gra_still_q, gra_still_d;
    logic          serve_q,     serve_d;
    logic          game_over_q, game_over_d;

    logic          start_req;
    logic          score_clr;
    logic          score_inc;

    assign start_req = |btn;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        lives_d   = lives_q;
        serve_d   = 1'b0;
        score_clr = 1'b0;
        score_inc = 1'b0;

        // Frame countdown holds at zero; any load below overrides it.
        if (refr_tick && (timer_q != '0)) begin
            timer_d = timer_q - 1'b1;
        end

        case (state_q)
            ST_NEWGAME: begin
                if (start_req) begin
                    state_d   = ST_PLAY;
                    score_clr = 1'b1;
                    lives_d   = C_LIVES_INIT;
                    serve_d   = 1'b1;
                end
            end
            ST_PLAY: begin
                // A miss takes priority over a simultaneous hit.
                if (miss) begin
                    if (lives_q <= 2'd1) begin
                        state_d = ST_OVER;
                        lives_d = 2'd0;
                        timer_d = C_OVER_LOAD;
                    end else begin
                        state_d = ST_NEWBALL;
                        lives_d = lives_q - 2'd1;
                        timer_d = C_SERVE_LOAD;
                    end
                end else if (hit) begin
                    score_inc = 1'b1;
                end
            end
            ST_NEWBALL: begin
                if ((timer_q == '0) && start_req) begin
                    state_d = ST_PLAY;
                    serve_d = 1'b1;
                end
            end
            ST_OVER: begin
                if (timer_q == '0) begin
                    state_d = ST_NEWGAME;
                end
            end
            default: begin
                state_d = ST_NEWGAME;
            end
        endcase

        // Decoded from the next state so these flags move with the state register.
        gra_still_d = (state_d != ST_PLAY);
        game_over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_NEWGAME;
            timer_q     <= '0;
            lives_q     <= C_LIVES_INIT;
            gra_still_q <= 1'b1;
            serve_q     <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            lives_q     <= lives_d;
            gra_still_q <= gra_still_d;
            serve_q     <= serve_d;
            game_over_q <= game_over_d;
        end
    end

    bcd2_counter u_score (
        .clk (clk),
        .rst (rst),
        .clr (score_clr),
        .inc (score_inc),
        .d1  (score_d1),
        .d0  (score_d0)
    );

    assign gra_still = gra_still_q;
    assign serve     = serve_q;
    assign lives     = lives_q;
    assign game_over = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pong_game_ctrl
// Description : Self-checking bench for pong_game_ctrl. A game-level model
//               (mode, integer score, lives, frame countdown) predicts every
//               registered output; directed scenarios plus a random run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_game_ctrl;

    localparam int LIVES  = 3;
    localparam int SERVE  = 120;
    localparam int OVER   = 180;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] btn = 2'b00;
    logic       refr_tick = 1'b0;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic       gra_still;
    logic       serve;
    logic [3:0] score_d1;
    logic [3:0] score_d0;
    logic [1:0] lives;
    logic       game_over;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pong_game_ctrl #(
        .LIVES_INIT   (LIVES),
        .SERVE_FRAMES (SERVE),
        .OVER_FRAMES  (OVER),
        .TW           (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .refr_tick (refr_tick),
        .hit       (hit),
        .miss      (miss),
        .gra_still (gra_still),
        .serve     (serve),
        .score_d1  (score_d1),
        .score_d0  (score_d0),
        .lives     (lives),
        .game_over (game_over)
    );

    // ------------------------------------------------------------------
    // Game-level reference model
    // ------------------------------------------------------------------
    typedef enum int {M_IDLE, M_RALLY, M_WAIT, M_GAMEOVER} mode_t;
    mode_t m_mode;
    int    m_score;
    int    m_lives;
    int    m_timer;
    bit    m_serve;

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_score = 0;
        m_lives = LIVES;
        m_timer = 0;
        m_serve = 0;
    endtask

    task automatic model_step(input logic [1:0] b, input logic t, input logic h, input logic m);
        m_serve = 0;
        case (m_mode)
            M_IDLE: if (b != 0) begin
                m_mode = M_RALLY; m_score = 0; m_lives = LIVES; m_serve = 1;
            end
            M_RALLY: if (m) begin
                m_lives = m_lives - 1;
                if (m_lives == 0) begin m_mode = M_GAMEOVER; m_timer = OVER; end
                else begin m_mode = M_WAIT; m_timer = SERVE; end
            end else if (h) begin
                m_score = (m_score < 99) ? m_score + 1 : 99;
            end
            M_WAIT: if (m_timer == 0 && b != 0) begin
                m_mode = M_RALLY; m_serve = 1;
            end else if (t && m_timer > 0) begin
                m_timer = m_timer - 1;
            end
            M_GAMEOVER: if (m_timer == 0) m_mode = M_IDLE;
                        else if (t) m_timer = m_timer - 1;
            default: m_mode = M_IDLE;
        endcase
    endtask

    // {gra_still, serve, tens, ones, lives, game_over}
    function automatic logic [12:0] exp_vec();
        logic [3:0] tens, ones;
        tens = 4'(m_score / 10);
        ones = 4'(m_score % 10);
        return {(m_mode != M_RALLY), m_serve, tens, ones, 2'(m_lives), (m_mode == M_GAMEOVER)};
    endfunction

    function automatic logic [12:0] dut_vec();
        return {gra_still, serve, score_d1, score_d0, lives, game_over};
    endfunction

    // Drive one clock's worth of inputs, advance the model, sample after edge.
    task automatic cycle(input logic [1:0] b, input logic t, input logic h, input logic m);
        btn = b; refr_tick = t; hit = h; miss = m;
        @(posedge clk);
        model_step(b, t, h, m);
        #1;
    endtask

    task automatic assert_rst();
        btn = 2'b00; refr_tick = 1'b0; hit = 1'b0; miss = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1;
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        @(posedge clk); #1;
        assert_rst();
        checks++;
        if (dut_vec() !== 13'b1_0_0000_0000_11_0) begin
            failures++; $display("FAIL reset_vec act=%h exp=%h", dut_vec(), 13'b1_0_0000_0000_11_0);
        end
        @(posedge clk); #1;
        checks++;
        if (dut_vec() !== exp_vec()) begin
            failures++; $display("FAIL reset_hold act=%h exp=%h", dut_vec(), exp_vec());
        end
        release_rst();
    endtask

    task automatic test_start();
        cycle(2'b01, 0, 0, 0);
        checks++;
        if (serve !== 1'b1 || gra_still !== 1'b0 || lives !== 2'd3 || score_d1 !== 4'd0 || score_d0 !== 4'd0) begin
            failures++; $display("FAIL start_outputs act=%h exp=%h", dut_vec(), 13'b0_1_0000_0000_11_0);
        end
        cycle(2'b01, 0, 0, 0);
        checks++;
        if (serve !== 1'b0) begin
            failures++; $display("FAIL start_serve_width act=%b exp=0", serve);
        end
        checks++;
        if (dut_vec() !== exp_vec()) begin
            failures++; $display("FAIL start_vec act=%h exp=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_score();
        for (int i = 0; i < 12; i++) cycle(2'b00, 1'($urandom_range(0, 1)), 1, 0);
        checks++;
        if (score_d1 !== 4'd1 || score_d0 !== 4'd2) begin
            failures++; $display("FAIL score_12 act=%h%h exp=12", score_d1, score_d0);
        end
        for (int i = 0; i < 90; i++) begin
            cycle(2'b00, 0, 1, 0);
            if (dut_vec() !== exp_vec()) begin
                failures++; $display("FAIL score_step%0d act=%h exp=%h", i, dut_vec(), exp_vec());
            end
            checks++;
        end
        checks++;
        if (score_d1 !== 4'd9 || score_d0 !== 4'd9) begin
            failures++; $display("FAIL score_saturate act=%h%h exp=99", score_d1, score_d0);
        end
    endtask

    task automatic test_hit_miss_same();
        cycle(2'b00, 0, 1, 1);
        checks++;
        if (lives !== 2'd2 || score_d1 !== 4'd9 || score_d0 !== 4'd9 || gra_still !== 1'b1 || serve !== 1'b0) begin
            failures++; $display("FAIL hit_miss_same act=%h exp=%h", dut_vec(), 13'b1_0_1001_1001_10_0);
        end
    endtask

    task automatic test_newball_wait();
        int  ticks = 0;
        bit  seen  = 0;
        for (int i = 0; i < 1000; i++) begin
            logic t;
            t = 1'(i % 2);
            cycle(2'b01, t, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++; $display("FAIL newball_cycle%0d act=%h exp=%h", i, dut_vec(), exp_vec());
            end
            if (serve === 1'b1) begin seen = 1; break; end
            ticks += int'(t);
        end
        checks++;
        if (!seen) begin
            failures++; $display("FAIL newball_timeout act=no_serve exp=serve");
        end
        checks++;
        if (ticks != SERVE) begin
            failures++; $display("FAIL newball_ticks act=%0d exp=%0d", ticks, SERVE);
        end
        checks++;
        if (gra_still !== 1'b0) begin
            failures++; $display("FAIL newball_resume act=%b exp=0", gra_still);
        end
    endtask

    task automatic test_game_over();
        int  ticks = 0;
        bit  seen  = 0;
        cycle(2'b00, 0, 0, 1);               // lives 2 -> 1
        for (int i = 0; i < SERVE + 2; i++) cycle(2'b00, 1, 0, 0);
        cycle(2'b10, 0, 0, 0);               // serve
        cycle(2'b00, 0, 0, 0);
        cycle(2'b00, 0, 0, 1);               // lives 1 -> 0
        checks++;
        if (lives !== 2'd0 || game_over !== 1'b1 || gra_still !== 1'b1) begin
            failures++; $display("FAIL over_enter act=%h exp=%h", dut_vec(), 13'b1_0_1001_1001_00_1);
        end
        for (int i = 0; i < 1000; i++) begin
            cycle(2'b01, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++; $display("FAIL over_cycle%0d act=%h exp=%h", i, dut_vec(), exp_vec());
            end
            if (game_over === 1'b0) begin seen = 1; break; end
            ticks++;
        end
        checks++;
        if (!seen || ticks != OVER) begin
            failures++; $display("FAIL over_hold act=%0d exp=%0d", ticks, OVER);
        end
        checks++;
        if (score_d1 !== 4'd9 || score_d0 !== 4'd9 || lives !== 2'd0) begin
            failures++; $display("FAIL over_retain act=%h exp=%h", dut_vec(), 13'b1_0_1001_1001_00_0);
        end
        cycle(2'b11, 0, 0, 0);
        checks++;
        if (score_d1 !== 4'd0 || score_d0 !== 4'd0 || lives !== 2'd3 || serve !== 1'b1) begin
            failures++; $display("FAIL restart_clear act=%h exp=%h", dut_vec(), 13'b0_1_0000_0000_11_0);
        end
    endtask

    task automatic test_reset_mid();
        cycle(2'b00, 0, 1, 0);
        cycle(2'b00, 0, 1, 0);
        assert_rst();
        checks++;
        if (dut_vec() !== exp_vec()) begin
            failures++; $display("FAIL rst_mid_play act=%h exp=%h", dut_vec(), exp_vec());
        end
        release_rst();
        cycle(2'b00, 0, 1, 0);
        cycle(2'b00, 1, 0, 1);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            failures++; $display("FAIL newgame_ignore act=%h exp=%h", dut_vec(), exp_vec());
        end
        cycle(2'b01, 0, 0, 0);               // start
        checks++;
        if (dut_vec() !== exp_vec()) begin
            failures++; $display("FAIL rst_restart act=%h exp=%h", dut_vec(), exp_vec());
        end
        assert_rst();                        // lands while serve is high
        checks++;
        if (serve !== 1'b0 || dut_vec() !== exp_vec()) begin
            failures++; $display("FAIL rst_during_serve act=%h exp=%h", dut_vec(), exp_vec());
        end
        release_rst();
        cycle(2'b01, 0, 0, 0);
        cycle(2'b00, 0, 0, 1);               // into NEWBALL
        for (int i = 0; i < 5; i++) cycle(2'b00, 1, 0, 0);
        assert_rst();
        checks++;
        if (dut_vec() !== exp_vec()) begin
            failures++; $display("FAIL rst_mid_newball act=%h exp=%h", dut_vec(), exp_vec());
        end
        release_rst();
        cycle(2'b00, 0, 0, 0);
        checks++;
        if (serve !== 1'b0 || dut_vec() !== exp_vec()) begin
            failures++; $display("FAIL rst_no_serve act=%h exp=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            logic [1:0] b;
            b = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            cycle(b, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 40) == 0));
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++; $display("FAIL random_cycle%0d act=%h exp=%h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_start();
        test_score();
        test_hit_miss_same();
        test_newball_wait();
        test_game_over();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game-level sequencer for the Pong animated-graphics datapath. Decides when the ball/paddle animation runs or freezes, issues the serve pulse that reloads the ball, counts hits as a two-digit BCD score and tracks remaining lives. Sits between the button/frame-tick sources and the animated graphics block. Also drives the score/lives text overlay.

Parameters:
LIVES_INIT, 3, lives loaded at game start (1..3)
SERVE_FRAMES, 120, refresh ticks to wait after a miss before serving is allowed (2 s at 60 Hz)
OVER_FRAMES, 180, refresh ticks the game-over screen is held
TW, 8, timer width; must hold max(SERVE_FRAMES, OVER_FRAMES)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
btn  in  2  paddle buttons; any bit high = "start/serve" request
refr_tick  in  1  one-cycle pulse per frame (pix_y==481, pix_x==0)
hit  in  1  one-cycle pulse: ball bounced off paddle
miss  in  1  one-cycle pulse: ball passed right edge
gra_still  out  1  1 = freeze ball and paddle motion
serve  out  1  one-cycle pulse: reload ball to start position/velocity
score_d1  out  4  BCD tens digit of score
score_d0  out  4  BCD ones digit of score
lives  out  2  remaining lives
game_over  out  1  high while in OVER state

Behaviour:
- All outputs registered. Async reset sets: state=NEWGAME, timer=0, lives=LIVES_INIT, score=00, gra_still=1, serve=0, game_over=0.
- States: NEWGAME, PLAY, NEWBALL, OVER (2-bit encoding).
- NEWGAME: gra_still=1. If btn!=0: go to PLAY, score<=00, lives<=LIVES_INIT, serve=1 in the next cycle (exactly one cycle).
- PLAY: gra_still=0.
  - hit: BCD increment. d0 9->0 carries into d1. Saturates at 99; further hits hold 99.
  - miss: lives<=lives-1.
    - If lives was 1: go to OVER, lives=0, timer<=OVER_FRAMES.
    - Otherwise: go to NEWBALL, timer<=SERVE_FRAMES.
  - hit and miss in the same cycle: miss wins, score unchanged.
- NEWBALL: gra_still=1. Timer decrements by 1 on each refr_tick and holds at 0. When timer==0 and btn!=0: go to PLAY and pulse serve. A btn held down through expiry serves on the first cycle timer==0. hit/miss ignored.
- OVER: gra_still=1, game_over=1. Timer decrements on refr_tick. At timer==0: go to NEWGAME, game_over<=0. Score and lives (0) hold until the next start.
- Timer load and refr_tick in the same cycle: the load wins.
- hit/miss outside PLAY are ignored. serve never asserts in two consecutive cycles.
- gra_still and game_over update in the same cycle as the state register (registered alongside it).
- rst asserted mid-game returns everything immediately to reset values; no serve pulse is generated.

Decomposition:
- Shared package/header holds the state encodings (ST_NEWGAME=0, ST_PLAY=1, ST_NEWBALL=2, ST_OVER=3) and the BCD max constant 9.
- One sub-module is natural: bcd2_counter (clear, inc, saturate at 99, outputs d1/d0), instantiated once for the score.
- The frame-tick down-counter stays inline.

Test Plan:
- Reset then btn=01 for 1 cycle -> serve high exactly 1 cycle; gra_still=0; lives=3; score=00.
- In PLAY, 12 hit pulses -> score_d1=1, score_d0=2. Preload 99 then one hit -> stays 99.
- hit and miss in the same cycle with lives=3 -> lives=2, score unchanged, state NEWBALL, gra_still=1.
- In NEWBALL with btn held: no serve before 120 refr_ticks; serve pulses on the first cycle the timer reaches 0; back in PLAY.
- Three misses -> lives 3->2->1->0, game_over=1. After 180 refr_ticks -> NEWGAME, game_over=0, score retained. Next btn clears the score to 00.
- rst pulsed mid-PLAY and mid-NEWBALL timer -> all outputs at reset values that cycle; no serve; hit/miss during NEWGAME ignored.
